dcache_miss_controller: RTL and testbench

Sequences data-cache miss handling between `data_cache` and main memory. On a miss it writes back the victim block if it is dirty, fetches the missing 256-bit block, and then presents it to the cache with a one-cycle `newblockloaded` pulse. It sits between the cache's miss outputs (`getnewblock`, `changedblock`, `dirtytag`) and a single-port block-wide main memory with a request/ready handshake. It also keeps saturating miss and writeback counters for performance readout.

---
 rtl/dcache_miss_controller.sv | 120 ++++++++++++
 tb/tb_dcache_miss_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_controller.sv
// Data-cache miss sequencer: optional dirty-victim writeback, block fill from
// main memory, then a one-cycle newblockloaded pulse; keeps saturating stats.
module dcache_miss_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             getnewblock,
  input  logic             wb_needed,
  input  logic [15:0]      pc,
  input  logic [255:0]     changedblock,
  input  logic [5:0]       dirtytag,
  output logic             mem_req,
  output logic             mem_we,
  output logic [11:0]      mem_addr,
  output logic [255:0]     mem_wdata,
  input  logic [255:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [255:0]     newblock,
  output logic             newblockloaded,
  output logic             busy,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [1:0]       fsm_state
);

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable until
  // the cycle in which mem_ready=1 is sampled; that edge completes the transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic         wb_done;
  logic         fill_done;
  logic [11:0]  fill_addr;
  logic [11:0]  wb_addr;
  logic [255:0] wb_data;
  logic         unused_pc_word;

  // Word offset is irrelevant to block-granular memory traffic.
  assign unused_pc_word = ^pc[3:0];
  assign fsm_state      = state;

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    wb_done        = 1'b0;
    fill_done      = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 12'd0;
    mem_wdata      = 256'd0;
    newblockloaded = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (getnewblock) begin
          accept     = 1'b1;
          state_next = wb_needed ? WB : FILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_addr;
        mem_wdata = wb_data;
        if (mem_ready) begin
          wb_done    = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = fill_addr;
        if (mem_ready) begin
          fill_done  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        newblockloaded = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fill_addr  <= 12'd0;
      wb_addr    <= 12'd0;
      wb_data    <= 256'd0;
      newblock   <= 256'd0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_next;
      // Miss context is captured once so the cache may change its outputs mid-miss.
      if (accept) begin
        fill_addr <= pc[15:4];
        wb_addr   <= {dirtytag, pc[9:4]};
        wb_data   <= changedblock;
        if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_ONE;
      end
      if (wb_done && (wb_count != CNT_MAX)) wb_count <= wb_count + CNT_ONE;
      if (fill_done) newblock <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Bench for dcache_miss_controller: directed and randomized misses checked
// against a transaction-level model of the miss sequence and counters.
module tb_dcache_miss_controller;

  localparam int CNT_W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         getnewblock;
  logic         wb_needed;
  logic [15:0]  pc;
  logic [255:0] changedblock;
  logic [5:0]   dirtytag;
  logic [255:0] mem_rdata;
  logic         mem_ready;

  logic         mem_req, mem_we, newblockloaded, busy;
  logic [11:0]  mem_addr;
  logic [255:0] mem_wdata, newblock;
  logic [CNT_W-1:0] miss_count, wb_count;
  logic [1:0]   fsm_state;

  logic         s_mem_req, s_mem_we, s_newblockloaded, s_busy;
  logic [11:0]  s_mem_addr;
  logic [255:0] s_mem_wdata, s_newblock;
  logic [1:0]   s_miss_count, s_wb_count, s_fsm_state;

  dcache_miss_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .getnewblock(getnewblock), .wb_needed(wb_needed),
    .pc(pc), .changedblock(changedblock), .dirtytag(dirtytag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .newblock(newblock),
    .newblockloaded(newblockloaded), .busy(busy), .miss_count(miss_count),
    .wb_count(wb_count), .fsm_state(fsm_state)
  );

  dcache_miss_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .getnewblock(getnewblock), .wb_needed(wb_needed),
    .pc(pc), .changedblock(changedblock), .dirtytag(dirtytag),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .newblock(s_newblock),
    .newblockloaded(s_newblockloaded), .busy(s_busy), .miss_count(s_miss_count),
    .wb_count(s_wb_count), .fsm_state(s_fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard and model state
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_miss   = 0;
  int           n_wb     = 0;
  logic [255:0] exp_q[$];
  logic [255:0] last_block = '0;

  function automatic int sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string where);
    check({where, " miss_count"}, miss_count, sat(n_miss, CNT_W));
    check({where, " wb_count"}, wb_count, sat(n_wb, CNT_W));
    check({where, " sat miss_count"}, s_miss_count, sat(n_miss, 2));
    check({where, " sat wb_count"}, s_wb_count, sat(n_wb, 2));
  endtask

  task automatic check_idle(input string where);
    check({where, " busy"}, busy, 0);
    check({where, " mem_req"}, mem_req, 0);
    check({where, " mem_we"}, mem_we, 0);
    check({where, " mem_addr"}, mem_addr, 0);
    check({where, " mem_wdata"}, mem_wdata, 0);
    check({where, " newblockloaded"}, newblockloaded, 0);
    check({where, " newblock"}, newblock, last_block);
    check_counts(where);
  endtask

  // Drivers: inputs change at negedge, outputs checked at negedge.
  task automatic scramble();
    pc           = $urandom_range(0, 1) ? 16'hffff : 16'($urandom());
    dirtytag     = 6'($urandom());
    changedblock = rand256();
    wb_needed    = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n, input logic rdy);
    getnewblock = 1'b0;
    for (int k = 0; k < n; k++) begin
      mem_ready = rdy;
      mem_rdata = rand256();
      scramble();
      @(negedge clk);
      check_idle("idle");
    end
    mem_ready = 1'b0;
  endtask

  // One complete miss, starting and ending on the negedge of an IDLE cycle.
  task automatic do_miss(input logic [15:0] a, input logic dirty, input logic [5:0] dt,
                         input logic [255:0] cb, input int wbw, input int fw,
                         input logic [255:0] rd, input logic hold);
    logic [11:0] exp_wb_addr;
    logic [11:0] exp_fill_addr;
    exp_wb_addr   = {dt, a[9:4]};
    exp_fill_addr = a[15:4];
    getnewblock  = 1'b1;
    wb_needed    = dirty;
    pc           = a;
    dirtytag     = dt;
    changedblock = cb;
    mem_ready    = 1'($urandom_range(0, 1));
    mem_rdata    = rand256();
    @(negedge clk);
    n_miss++;
    exp_q.push_back(rd);
    check("accept busy", busy, 1);
    check_counts("accept");
    if (dirty) begin
      for (int i = 0; i <= wbw; i++) begin
        check("wb mem_req", mem_req, 1);
        check("wb mem_we", mem_we, 1);
        check("wb mem_addr", mem_addr, exp_wb_addr);
        check("wb mem_wdata", mem_wdata, cb);
        check("wb newblockloaded", newblockloaded, 0);
        scramble();
        mem_ready = (i == wbw);
        mem_rdata = rand256();
        @(negedge clk);
      end
      n_wb++;
    end
    for (int i = 0; i <= fw; i++) begin
      check("fill mem_req", mem_req, 1);
      check("fill mem_we", mem_we, 0);
      check("fill mem_addr", mem_addr, exp_fill_addr);
      check("fill mem_wdata", mem_wdata, 0);
      check("fill newblockloaded", newblockloaded, 0);
      check("fill wb_count", wb_count, sat(n_wb, CNT_W));
      scramble();
      mem_ready = (i == fw);
      mem_rdata = (i == fw) ? rd : rand256();
      @(negedge clk);
    end
    check("done newblockloaded", newblockloaded, 1);
    check("done busy", busy, 1);
    check("done mem_req", mem_req, 0);
    check("done mem_addr", mem_addr, 0);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected one block");
    end else begin
      check("done newblock", newblock, exp_q.pop_front());
    end
    check_counts("done");
    last_block  = rd;
    mem_ready   = 1'($urandom_range(0, 1));
    mem_rdata   = rand256();
    getnewblock = hold;
    @(negedge clk);
    check_idle("after done");
    mem_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    getnewblock  = 1'b0;
    wb_needed    = 1'b0;
    pc           = '0;
    changedblock = '0;
    dirtytag     = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");
    check("reset fsm_state", fsm_state, 0);

    idle(3, 1'b1);

    do_miss(16'h0ac1, 1'b0, 6'h00, 256'h0, 0, 0, {32{8'hA5}}, 1'b0);
    do_miss(16'h1234, 1'b1, 6'h3f, 256'h1, 0, 0, rand256(), 1'b0);
    idle(1, 1'b0);
    do_miss(16'h5678, 1'b1, 6'h2a, rand256(), 5, 3, rand256(), 1'b0);

    // getnewblock held through DONE: next accept in the following IDLE cycle
    do_miss(16'h9abc, 1'b0, 6'h01, rand256(), 0, 1, rand256(), 1'b1);
    do_miss(16'hdef0, 1'b1, 6'h15, rand256(), 1, 0, rand256(), 1'b0);

    // Reset for two cycles in the middle of a fill
    getnewblock = 1'b1;
    wb_needed   = 1'b0;
    pc          = 16'h4321;
    mem_ready   = 1'b0;
    @(negedge clk);
    check("pre-reset mem_req", mem_req, 1);
    reset       = 1'b1;
    getnewblock = 1'b0;
    n_miss      = 0;
    n_wb        = 0;
    last_block  = '0;
    exp_q.delete();
    @(negedge clk);
    check_idle("in reset 1");
    @(negedge clk);
    check_idle("in reset 2");
    reset = 1'b0;
    check("post-reset fsm_state", fsm_state, 0);
    idle(3, 1'b1);

    // Five clean misses saturate the 2-bit instance at 3
    for (int m = 0; m < 5; m++)
      do_miss(16'($urandom()), 1'b0, 6'($urandom()), rand256(), 0, 0, rand256(), 1'b0);

    for (int m = 0; m < 20; m++)
      do_miss(16'($urandom()), 1'($urandom_range(0, 1)), 6'($urandom()), rand256(),
              $urandom_range(0, 4), $urandom_range(0, 4), rand256(),
              (m < 19) ? 1'($urandom_range(0, 1)) : 1'b0);

    idle(2, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
